// File: rtl/fsm_ex_scheduler.sv
// -----------------------------------------------------------------------------
// fsm_ex_scheduler
//
// Round-robin scheduler that lets up to four requesters share one sequencing
// engine. A requester raises its req bit and holds it until it is acked.
// From IDLE the scheduler grants one requester, picked by a rotating priority
// pointer. It holds the engine start line high in RUN until the engine reports
// done, then pulses ack to the owner. It spends one RELEASE cycle with start
// low so the engine can clear its count, and then returns to IDLE.
//
// Optional feature (macro FSM_SCHED_TIMEOUT_EN):
//   An 8-bit RUN-cycle counter. If TIMEOUT RUN cycles pass without eng_done,
//   the job is abandoned: no ack, sticky err set, and the pointer moves past
//   the owner. If done and timeout fall in the same cycle, done wins. When the
//   macro is undefined there is no counter, err is tied low and RUN waits for
//   eng_done indefinitely.
//
// Handshake: req_i[i] is a level request. The grant is signalled by
// gnt_o[i]=1, which stays high from the grant through the end of RUN.
// Completion is a single-cycle ack_o[i] pulse. After the ack the requester
// may drop or keep req_i[i]. A kept request competes again under round-robin
// priority. Changes on req_i during RUN or RELEASE have no effect.
//
// Parameters:
//   N_REQ    number of requesters, 2..4
//   TIMEOUT  RUN-cycle limit, 1..255 (used only with FSM_SCHED_TIMEOUT_EN)
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   req_i        per-requester level request
//   gnt_o        one-hot grant, high from grant through end of RUN
//   ack_o        one-cycle completion pulse to the owner
//   owner_id_o   index of the current or last granted requester
//   busy_o       high whenever the FSM is not in IDLE
//   err_o        sticky timeout flag, cleared only by reset
//   eng_start_o  engine start input
//   eng_done_i   engine done output (registered inside the engine)
//   eng_state_i  engine state, monitor only
//   state_o      FSM state, debug visibility
// -----------------------------------------------------------------------------
module fsm_ex_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] ack_o,
    output logic [1:0]       owner_id_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             eng_start_o,
    input  logic             eng_done_i,
    input  logic [1:0]       eng_state_i,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;

`ifdef FSM_SCHED_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    // eng_state_i is for observation only and never steers control.
    logic unused_sink_c;
    assign unused_sink_c = ^{eng_state_i, 8'(TIMEOUT)};

    // -------------------------------------------------------------------------
    // Round-robin pick. Candidates are scanned ptr, ptr+1, ... modulo N_REQ.
    // The loop runs from the farthest candidate toward ptr so that the last
    // hit, which is the nearest one to ptr, is the one that sticks.
    // -------------------------------------------------------------------------
    logic [2:0] scan_c;
    logic [1:0] cand_c;
    logic       pick_valid_c;
    logic [1:0] pick_idx_c;

    always_comb begin
        scan_c       = '0;
        cand_c       = '0;
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_c = {1'b0, ptr_q} + 3'(i);
            if (scan_c >= 3'(N_REQ)) begin
                scan_c = scan_c - 3'(N_REQ);
            end
            cand_c = scan_c[1:0];
            if (req_i[cand_c]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    // The pointer moves to the slot after the owner once the job ends, so a
    // requester cannot be granted twice in a row while another one waits.
    logic [2:0] next_ptr_c;

    always_comb begin
        next_ptr_c = {1'b0, owner_q} + 3'd1;
        if (next_ptr_c >= 3'(N_REQ)) begin
            next_ptr_c = next_ptr_c - 3'(N_REQ);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        start_d = start_q;
`ifdef FSM_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pick_valid_c) begin
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_c;
                    owner_d = pick_idx_c;
                    start_d = 1'b1;
                    state_d = S_RUN;
`ifdef FSM_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            S_RUN: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (eng_done_i) begin
                    start_d = 1'b0;
                    gnt_d   = '0;
                    ack_d   = gnt_q;
                    ptr_d   = next_ptr_c[1:0];
                    state_d = S_RELEASE;
                end
`ifdef FSM_SCHED_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    start_d = 1'b0;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                    ptr_d   = next_ptr_c[1:0];
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end

            S_RELEASE: begin
                // Start stays low for this cycle so the engine clears its count.
                start_d = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                start_d = 1'b0;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

`ifdef FSM_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign ack_o       = ack_q;
    assign owner_id_o  = owner_q;
    assign busy_o      = busy_q;
    assign eng_start_o = start_q;
    assign state_o     = state_q;

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
    a_ack_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ack_q));
`endif

endmodule

// File: tb/tb_fsm_ex_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for fsm_ex_scheduler.
//
// The reference model works at job level. It keeps a set of pending
// requesters and a priority pointer. For each job it computes the winner by
// scanning from the pointer. It then predicts the cycle-exact output
// sequence from the job's latency (the RUN edge on which eng_done is seen)
// and, when FSM_SCHED_TIMEOUT_EN is defined, from TIMEOUT. Expected acks are
// queued at grant time and popped when the job completes.
// -----------------------------------------------------------------------------
module tb_fsm_ex_scheduler;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 20;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] gnt_o;
    logic [N_REQ-1:0] ack_o;
    logic [1:0]       owner_id_o;
    logic             busy_o;
    logic             err_o;
    logic             eng_start_o;
    logic             eng_done_i;
    logic [1:0]       eng_state_i;
    logic [1:0]       state_o;

    fsm_ex_scheduler #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .ack_o       (ack_o),
        .owner_id_o  (owner_id_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .eng_start_o (eng_start_o),
        .eng_done_i  (eng_done_i),
        .eng_state_i (eng_state_i),
        .state_o     (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          m_ptr;
    logic        m_err;
    logic [3:0]  m_pending;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int model_pick(input logic [3:0] pend, input int ptr);
        int idx;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (ptr + k) % N_REQ;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_gnt"},   32'(gnt_o),       32'd0);
        check_eq({tag, "_ack"},   32'(ack_o),       32'd0);
        check_eq({tag, "_start"}, 32'(eng_start_o), 32'd0);
        check_eq({tag, "_busy"},  32'(busy_o),      32'd0);
        check_eq({tag, "_err"},   32'(err_o),       32'(m_err));
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        req_i      = 4'hF;
        eng_done_i = 1'b0;
        step();
        m_ptr     = 0;
        m_err     = 1'b0;
        m_pending = '0;
        exp_q.delete();
        check_idle("reset");
        check_eq("reset_owner", 32'(owner_id_o), 32'd0);
        rst_i = 1'b0;
    endtask

    // One job from IDLE. lat = RUN edge on which eng_done is presented.
    task automatic run_job(input int lat);
        int          w;
        int          last;
        bit          timed_out;
        logic [31:0] exp_ack;
        w = model_pick(m_pending, m_ptr);
        req_i       = m_pending;
        eng_done_i  = 1'($urandom_range(0, 1));
        eng_state_i = 2'($urandom_range(0, 3));
        step();
        check_eq("grant_gnt",   32'(gnt_o),       32'(1) << w);
        check_eq("grant_owner", 32'(owner_id_o),  32'(w));
        check_eq("grant_start", 32'(eng_start_o), 32'd1);
        check_eq("grant_busy",  32'(busy_o),      32'd1);
        check_eq("grant_ack",   32'(ack_o),       32'd0);
        timed_out = 1'b0;
`ifdef FSM_SCHED_TIMEOUT_EN
        if (lat > TIMEOUT) timed_out = 1'b1;
`endif
        last = timed_out ? TIMEOUT : lat;
        if (!timed_out) exp_q.push_back(32'(1) << w);
        for (int k = 1; k <= last; k++) begin
            eng_done_i  = (k == lat);
            req_i       = 4'($urandom_range(0, 15));
            eng_state_i = 2'($urandom_range(0, 3));
            step();
            if (k < last) begin
                check_eq("run_gnt",   32'(gnt_o),       32'(1) << w);
                check_eq("run_start", 32'(eng_start_o), 32'd1);
                check_eq("run_ack",   32'(ack_o),       32'd0);
                check_eq("run_err",   32'(err_o),       32'(m_err));
            end
        end
        if (timed_out) begin
            m_err   = 1'b1;
            exp_ack = 32'd0;
        end else begin
            exp_ack      = exp_q.pop_front();
            m_pending[w] = 1'b0;
        end
        m_ptr = (w + 1) % N_REQ;
        check_eq("end_ack",   32'(ack_o),       exp_ack);
        check_eq("end_gnt",   32'(gnt_o),       32'd0);
        check_eq("end_start", 32'(eng_start_o), 32'd0);
        check_eq("end_busy",  32'(busy_o),      32'd1);
        check_eq("end_err",   32'(err_o),       32'(m_err));
        // RELEASE: eng_done and req are don't-care here.
        eng_done_i = 1'($urandom_range(0, 1));
        req_i      = 4'($urandom_range(0, 15));
        step();
        check_idle("release");
        check_eq("release_owner", 32'(owner_id_o), 32'(w));
        eng_done_i = 1'b0;
    endtask

    task automatic idle_step();
        req_i      = '0;
        eng_done_i = 1'($urandom_range(0, 1));
        step();
        check_idle("idle");
    endtask

    task automatic reset_mid_run();
        int w;
        w = model_pick(m_pending, m_ptr);
        req_i      = m_pending;
        eng_done_i = 1'b0;
        step();
        check_eq("mid_grant", 32'(gnt_o), 32'(1) << w);
        repeat (5) begin
            step();
            check_eq("mid_hold", 32'(gnt_o), 32'(1) << w);
        end
        rst_i = 1'b1;
        step();
        m_ptr = 0;
        m_err = 1'b0;
        check_idle("mid_reset");
        check_eq("mid_reset_owner", 32'(owner_id_o), 32'd0);
        rst_i = 1'b0;
        exp_q.delete();
        // Pointer was 1 before the reset; a full request must now go to 0.
        m_pending = 4'hF;
        run_job(14);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i       = 1'b1;
        req_i       = 4'hF;
        eng_done_i  = 1'b0;
        eng_state_i = 2'd0;
        m_ptr       = 0;
        m_err       = 1'b0;
        m_pending   = '0;

        // Reset held two cycles with all requests up.
        repeat (2) begin
            step();
            check_idle("reset_hold");
            check_eq("reset_hold_owner", 32'(owner_id_o), 32'd0);
        end
        rst_i = 1'b0;
        m_pending = 4'hF;
        run_job(14);

        // Single job with engine turnaround: ack after edge 15, idle after 16.
        do_reset();
        m_pending = 4'b0100;
        run_job(14);

        // Round robin with all four requesting.
        do_reset();
        m_pending = 4'hF;
        repeat (4) run_job(14);

        // Owner drops req mid-job, another index rises.
        m_pending = 4'b0010;
        run_job(9);
        m_pending = 4'b0001;
        run_job(5);

        repeat (3) idle_step();

        // Reset in the middle of RUN.
        m_pending = 4'b0001;
        run_job(3);
        m_pending = 4'b0100;
        reset_mid_run();

        // Done coinciding with the timeout limit, then a job past the limit.
        m_pending = 4'b1000;
        run_job(TIMEOUT);
        m_pending = m_pending | 4'b1001;
        run_job(TIMEOUT + 6);

        // Random traffic.
        repeat (40) begin
            m_pending = m_pending | 4'($urandom_range(0, 15));
            if (m_pending == 4'd0) idle_step();
            else run_job($urandom_range(1, TIMEOUT + 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
